fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set program address width (16-entry program space).
REQ-002 Parameter INST_W, default 16, SHALL set instruction width; opcode SHALL be bits [15:12], target field bits [11:8].
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rom_addr  output  ADDR_W  SHALL be the program address driven to the program store; equals current pc.
REQ-006 rom_data  input  INST_W  SHALL be the instruction returned combinationally for rom_addr in the same cycle.
REQ-007 redirect_valid  input  1  SHALL request a pc change from execute (taken br/jmp).
REQ-008 redirect_addr  input  ADDR_W  SHALL be the redirect target, sampled when redirect_valid=1.
REQ-009 halt  input  1  SHALL freeze pc and issue while high.
REQ-010 if_valid  output  1  SHALL mark if_inst/if_pc as a valid fetched instruction.
REQ-011 if_ready  input  1  SHALL be the downstream decode acceptance; transfer occurs when if_valid&if_ready.
REQ-012 if_inst  output  INST_W  SHALL be the registered instruction.
REQ-013 if_pc  output  ADDR_W  SHALL be the address from which if_inst was fetched.

Function
REQ-014 FSM SHALL have states BOOT, RUN, HALTED; BOOT->RUN on first clock after rst_n release; RUN->HALTED when halt=1; HALTED->RUN when halt=0.
REQ-015 In BOOT and HALTED, pc, if_inst, if_pc, if_valid SHALL hold (if_valid=0 in BOOT).
REQ-016 In RUN, "load" SHALL occur when (!if_valid | if_ready): if_inst<=rom_data, if_pc<=pc, if_valid<=1, pc<=pc+1.
REQ-017 In RUN with if_valid=1 and if_ready=0 (stall), pc, if_inst, if_pc, if_valid SHALL hold unchanged.
REQ-018 pc increment SHALL be modulo 2^ADDR_W (15 -> 0 wraps with no flag).
REQ-019 Fetch latency SHALL be one cycle: instruction at pc visible on if_inst the cycle after load.
REQ-020 redirect_valid=1 SHALL take priority over load, stall and halt: pc<=redirect_addr, if_valid<=0 next cycle (flush), if_inst/if_pc hold.
REQ-021 Redirect in BOOT SHALL still update pc; FSM proceeds to RUN normally.
REQ-022 halt asserted while if_valid=1 SHALL keep if_valid/if_inst held until if_ready accepts; then if_valid<=0, no new load until halt=0.
REQ-023 Throughput SHALL be one instruction per cycle with if_ready held high.

Reset
REQ-024 On rst_n=0, asynchronously: pc=0, if_inst=0, if_pc=0, if_valid=0, state=BOOT.
REQ-025 Reset mid-stall or mid-redirect SHALL discard all in-flight state; no instruction SHALL be re-issued after reset except by refetch from address 0.

Configuration
REQ-026 Macro FETCH_JMP_PREDECODE_EN SHALL enable jump predecode.
REQ-027 With macro defined: on a load where rom_data[15:12]=4'b1000 (jmp), pc<=rom_data[11:8] instead of pc+1; jmp still issued on if_inst; external redirect retains priority.
REQ-028 Without macro: jmp treated as any instruction (pc+1); jumps resolved only via redirect_valid.

Structure
REQ-029 Shared package proc_pkg SHALL hold ADDR_W, INST_W, opcode field positions, OP_JMP=4'b1000, OP_BR=4'b1100, OP_OUT=4'b1111, and the fetch state enum.
REQ-030 Sub-module fetch_predecode (combinational: is_jmp, jmp_target) SHALL be instantiated only under FETCH_JMP_PREDECODE_EN.

Verification
REQ-031 Reset, release, if_ready=1, store addr0..3 = 0x1E08,0x100A,0xF000,0xE1C0 -> if_inst sequence 0x1E08,0x100A,0xF000,0xE1C0 on consecutive cycles, if_pc 0..3, first valid 2 cycles after release.
REQ-032 Stall: if_ready=0 for 3 cycles while if_inst=0x100A -> if_inst/if_pc/rom_addr stable; after if_ready=1 next issue is addr2.
REQ-033 Redirect: redirect_valid=1, redirect_addr=9 while if_valid=1 -> next cycle if_valid=0, rom_addr=9; following cycle if_pc=9.
REQ-034 Wrap: pc=15 load -> if_pc=15 then next if_pc=0.
REQ-035 Macro defined, addr6=0x8000 -> if_pc=6 issued, next if_pc=0 with no bubble; macro undefined -> next if_pc=7.
REQ-036 rst_n pulsed low mid-stall at if_pc=5 -> outputs zero immediately (asynchronous), restart fetch from 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: widths, instruction field positions, opcodes, fetch FSM states.
// Used by fetch_unit and fetch_predecode.
package proc_pkg;
  localparam int ADDR_W = 4;
  localparam int INST_W = 16;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int TGT_HI = 11;
  localparam int TGT_LO = 8;

  localparam logic [3:0] OP_JMP = 4'b1000;
  localparam logic [3:0] OP_BR  = 4'b1100;
  localparam logic [3:0] OP_OUT = 4'b1111;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [3:0] get_opcode(input logic [INST_W-1:0] inst);
    return inst[OPC_HI:OPC_LO];
  endfunction
endpackage

// File: rtl/fetch_predecode.sv
// Combinational jump predecode: flags a jmp opcode and extracts its absolute target.
// Only instantiated when FETCH_JMP_PREDECODE_EN is defined.
module fetch_predecode
  import proc_pkg::*;
#(
  parameter int ADDR_W = proc_pkg::ADDR_W
) (
  input  logic [3:0]        opcode,
  input  logic [3:0]        target,
  output logic              is_jmp,
  output logic [ADDR_W-1:0] jmp_target
);
  assign is_jmp     = (opcode == OP_JMP);
  assign jmp_target = ADDR_W'(target);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: pc, one-entry registered issue slot, redirect/halt/stall handling.
// Optional jump predecode enabled by defining FETCH_JMP_PREDECODE_EN.
module fetch_unit
  import proc_pkg::*;
#(
  parameter int ADDR_W = proc_pkg::ADDR_W,
  parameter int INST_W = proc_pkg::INST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc
);
  fetch_state_e      state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s, seq_pc_s;
  logic [INST_W-1:0] if_inst_r, if_inst_nxt_s;
  logic [ADDR_W-1:0] if_pc_r, if_pc_nxt_s;
  logic              if_valid_r, if_valid_nxt_s;
  logic              load_s, drain_s;

`ifdef FETCH_JMP_PREDECODE_EN
  logic              is_jmp_s;
  logic [ADDR_W-1:0] jmp_target_s;

  fetch_predecode #(.ADDR_W(ADDR_W)) u_predecode (
    .opcode     (get_opcode(rom_data)),
    .target     (rom_data[TGT_HI:TGT_LO]),
    .is_jmp     (is_jmp_s),
    .jmp_target (jmp_target_s)
  );

  assign seq_pc_s = is_jmp_s ? jmp_target_s : pc_r + ADDR_W'(1);
`else
  assign seq_pc_s = pc_r + ADDR_W'(1);
`endif

  // A held instruction may still be accepted while halting; the slot then empties.
  assign load_s  = (state_r == ST_RUN) && !halt && (!if_valid_r || if_ready);
  assign drain_s = (((state_r == ST_RUN) && halt) || (state_r == ST_HALTED))
                   && if_valid_r && if_ready;

  // Next-state and next-datapath selection; redirect outranks every other action.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    if_inst_nxt_s  = if_inst_r;
    if_pc_nxt_s    = if_pc_r;
    if_valid_nxt_s = if_valid_r;

    case (state_r)
      ST_BOOT:   state_nxt_s = ST_RUN;
      ST_RUN:    if (halt) state_nxt_s = ST_HALTED; else state_nxt_s = ST_RUN;
      ST_HALTED: if (!halt) state_nxt_s = ST_RUN; else state_nxt_s = ST_HALTED;
      default:   state_nxt_s = ST_BOOT;
    endcase

    if (redirect_valid) begin
      pc_nxt_s       = redirect_addr;
      if_valid_nxt_s = 1'b0;
    end else if (load_s) begin
      if_inst_nxt_s  = rom_data;
      if_pc_nxt_s    = pc_r;
      if_valid_nxt_s = 1'b1;
      pc_nxt_s       = seq_pc_s;
    end else if (drain_s) begin
      if_valid_nxt_s = 1'b0;
    end else begin
      if_valid_nxt_s = if_valid_r;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_BOOT;
      pc_r       <= '0;
      if_inst_r  <= '0;
      if_pc_r    <= '0;
      if_valid_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      if_inst_r  <= if_inst_nxt_s;
      if_pc_r    <= if_pc_nxt_s;
      if_valid_r <= if_valid_nxt_s;
    end
  end

  assign rom_addr = pc_r;
  assign if_inst  = if_inst_r;
  assign if_pc    = if_pc_r;
  assign if_valid = if_valid_r;
endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven directed bench for fetch_unit with a bench-owned 16-entry program store.
// Expected values around the jmp at address 6 depend on FETCH_JMP_PREDECODE_EN.
module tb_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        redirect_valid;
  logic [3:0]  redirect_addr;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_inst;
  logic [3:0]  if_pc;

  int checks;
  int failures;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [3:0]  ra;
    logic        hlt;
    logic        ev;
    logic [3:0]  epc;
    logic [15:0] einst;
    logic [3:0]  erom;
  } vec_t;

  vec_t vecs[$];

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt           (halt),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc)
  );

  function automatic logic [15:0] rom_val(input logic [3:0] a);
    case (a)
      4'd0:    return 16'h1E08;
      4'd1:    return 16'h100A;
      4'd2:    return 16'hF000;
      4'd3:    return 16'hE1C0;
      4'd6:    return 16'h8000;
      default: return 16'h2000 + {12'h000, a};
    endcase
  endfunction

  assign rom_data = rom_val(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_JMP_PREDECODE_EN
  localparam logic [3:0] JA = 4'd0;
`else
  localparam logic [3:0] JA = 4'd7;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [3:0] epc,
                         input logic [15:0] einst, input logic [3:0] erom);
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, ev});
    chk({tag, ".if_pc"},    {28'd0, if_pc},    {28'd0, epc});
    chk({tag, ".if_inst"},  {16'd0, if_inst},  {16'd0, einst});
    chk({tag, ".rom_addr"}, {28'd0, rom_addr}, {28'd0, erom});
  endtask

  task automatic step(input string tag, input vec_t v);
    if_ready       = v.rdy;
    redirect_valid = v.rv;
    redirect_addr  = v.ra;
    halt           = v.hlt;
    @(posedge clk);
    #1;
    chk_out(tag, v.ev, v.epc, v.einst, v.erom);
  endtask

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [3:0] ra,
                              input logic hlt, input logic ev, input logic [3:0] epc,
                              input logic [15:0] einst, input logic [3:0] erom);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.ra = ra; v.hlt = hlt;
    v.ev = ev; v.epc = epc; v.einst = einst; v.erom = erom;
    return v;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = 4'd0;
    halt = 1'b0;

    // boot, first fetches, stall on 0x100A
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd0));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 16'h1E08, 4'd1));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 16'h100A, 4'd2));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 16'h100A, 4'd2));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 16'hF000, 4'd3));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 16'hE1C0, 4'd4));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 16'h2004, 4'd5));
    // redirect to 9 flushes, then streams through the 15 -> 0 wrap
    vecs.push_back(mk(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 4'd4, 16'h2004, 4'd9));
    for (int a = 9; a <= 15; a++)
      vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'(a), rom_val(4'(a)), 4'(a + 1)));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 16'h1E08, 4'd1));
    // redirect to 5, then the jmp at 6
    vecs.push_back(mk(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 16'h1E08, 4'd5));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 16'h2005, 4'd6));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 16'h8000, JA));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, JA, rom_val(JA), JA + 4'd1));
    // halt while holding an unaccepted instruction, drain, release
    vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, JA, rom_val(JA), JA + 4'd1));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, JA, rom_val(JA), JA + 4'd1));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, JA, rom_val(JA), JA + 4'd1));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, JA, rom_val(JA), JA + 4'd1));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, JA, rom_val(JA), JA + 4'd1));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, JA + 4'd1, rom_val(JA + 4'd1), JA + 4'd2));

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 4'd0, 16'h0000, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i]);

    // asynchronous reset in the middle of a stall at if_pc=5
    step("st_redir", mk(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, JA + 4'd1, rom_val(JA + 4'd1), 4'd5));
    step("st_load",  mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 16'h2005, 4'd6));
    step("st_stall", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 16'h2005, 4'd6));
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 4'd0, 16'h0000, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("rs_boot",  mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd0));
    step("rs_first", mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 16'h1E08, 4'd1));

    // redirect during the boot cycle still steers pc
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_out("rst2", 1'b0, 4'd0, 16'h0000, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("boot_redir", mk(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd3));
    step("boot_load",  mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 16'hE1C0, 4'd4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
